ahb_sram_slave: RTL

AHB slave endpoint hanging off one slave port of the generated AHB bus (hsel_slave_N / slave_N_in / slave_N_out). It is word-addressed on-chip SRAM with a programmable number of wait states and a two-cycle ERROR response. It is the standard downstream consumer that the bus regression instantiates on every slave port.

---
 rtl/ahb_sram_slave.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-addressed memory, fixed wait states, two-cycle ERROR.
// Optional write protection input enabled by defining AHB_SRAM_WPROT_EN.
module ahb_sram_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
`ifdef AHB_SRAM_WPROT_EN
   input  logic              wprot,
`endif
   output logic              hreadyout,
   output logic [1:0]        hresp,
   output logic [DATA_W-1:0] hrdata
);

   localparam int         IDX_W   = $clog2(MEM_DEPTH);
   localparam logic [2:0] WS_LAST = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] ERROR   = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        lane_q, lane_d;
   logic [1:0]        size_q, size_d;
   logic              write_q, write_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic       accept;
   logic       can_accept;
   logic       out_of_range;
   logic       misaligned;
   logic       prot_err;
   logic       xfer_err;
   logic [3:0] byte_en;
   logic       unused_bits;

   assign unused_bits = ^{hburst, htrans[0]};

   assign accept       = hsel & hready & htrans[1];
   assign can_accept   = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign out_of_range = |(haddr >> (IDX_W + 2));
   assign misaligned   = ((hsize == 3'b001) && haddr[0]) ||
                         ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
`ifdef AHB_SRAM_WPROT_EN
   assign prot_err     = hwrite & wprot;
`else
   assign prot_err     = 1'b0;
`endif
   assign xfer_err     = out_of_range || (hsize > 3'b010) || misaligned || prot_err;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lane_d    = lane_q;
      size_d    = size_q;
      write_d   = write_q;
      cnt_d     = cnt_q;
      hreadyout = 1'b1;
      hresp     = OKAY;
      case (state_q)
         S_WAIT: begin
            hreadyout = 1'b0;
            if (cnt_q == WS_LAST) state_d = S_DATA;
            else                  cnt_d   = cnt_q + 3'd1;
         end
         S_DATA: state_d = S_IDLE;
         S_ERR1: begin
            hreadyout = 1'b0;
            hresp     = ERROR;
            state_d   = S_ERR2;
         end
         S_ERR2: begin
            hresp   = ERROR;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // An accept overrides the default successor so back-to-back beats pipeline.
      if (can_accept && accept) begin
         idx_d   = haddr[IDX_W+1:2];
         lane_d  = haddr[1:0];
         size_d  = hsize[1:0];
         write_d = hwrite;
         cnt_d   = '0;
         if (xfer_err)             state_d = S_ERR1;
         else if (WAIT_STATES > 0) state_d = S_WAIT;
         else                      state_d = S_DATA;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      case (size_q)
         2'b00:   byte_en = 4'b0001 << lane_q;
         2'b01:   byte_en = 4'b0011 << {lane_q[1], 1'b0};
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hreset && (state_q == S_DATA) && write_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

   assign hrdata = ((state_q == S_WAIT) || (state_q == S_DATA)) ? mem[idx_q] : '0;

endmodule
